wb_scoreboard: RTL and testbench

//  In-flight instruction tracker at the receiving end of the dual writeback interface. Hands out

---
 rtl/wb_scoreboard_pkg.sv | 39 +++
 rtl/wb_scoreboard_age_cmp.sv | 30 +++
 rtl/wb_scoreboard.sv | 183 ++++++++++++++++++
 tb/tb_wb_scoreboard.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_scoreboard_pkg.sv
//------------------------------------------------------------------------------
// Module   : wb_scoreboard_pkg
// Purpose  : Shared sizing, sid helpers and entry layout for the writeback
//            scoreboard. SCOREBOARD_SIZE_WIDTH sets log2 of the entry count
//            and may be overridden on the command line.
// Ports    : none (package)
// Config   : `SCOREBOARD_SIZE_WIDTH (default 3 -> 8 entries)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 3
`endif

package wb_scoreboard_pkg;

   localparam int IDX_W    = `SCOREBOARD_SIZE_WIDTH;
   localparam int SB_DEPTH = 1 << IDX_W;
   // One extra MSB acts as a wrap bit so full and empty are distinguishable.
   localparam int SID_W    = IDX_W + 1;

   typedef logic [SID_W-1:0] sid_t;

   // Packed entry layout, MSB first: {valid, done, wen, rd[4:0]}.
   typedef struct packed {
      logic       valid;
      logic       done;
      logic       wen;
      logic [4:0] rd;
   } sb_entry_t;

   function automatic logic [IDX_W-1:0] sid_idx(input sid_t sid);
      return sid[IDX_W-1:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/wb_scoreboard_age_cmp.sv
//------------------------------------------------------------------------------
// Module   : sb_age_cmp
// Purpose  : Age comparator relative to the scoreboard head. younger is set
//            when sid is strictly younger than ref_sid, where age is
//            (sid - head) modulo the sid space.
// Ports    : sid, head, ref_sid (SID_W in), younger (1 out)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sb_age_cmp
   import wb_scoreboard_pkg::*;
(
   input  logic [SID_W-1:0] sid,
   input  logic [SID_W-1:0] head,
   input  logic [SID_W-1:0] ref_sid,
   output logic             younger
);

   logic [SID_W-1:0] w_age_sid;
   logic [SID_W-1:0] w_age_ref;

   // Modular subtraction folds the wrap bit into a plain distance from head.
   assign w_age_sid = sid - head;
   assign w_age_ref = ref_sid - head;
   assign younger   = (w_age_sid > w_age_ref);

endmodule

`default_nettype wire

// File: rtl/wb_scoreboard.sv
//------------------------------------------------------------------------------
// Module   : wb_scoreboard
// Purpose  : In-flight instruction tracker. Allocates sids at issue (up to
//            two per cycle), marks entries done from two writeback ports,
//            retires up to two done entries in order per cycle, squashes
//            entries younger than a redirecting sid and publishes per-register
//            busy bits.
// Ports    : clk, rst_n               clock / async active-low reset
//            iss{0,1}_valid/wen/rd_i  issue requests
//            alloc_ready_o            at least two free entries
//            iss{0,1}_sid_o           sids handed to the issue slots
//            wb{0,1}_valid/sid_i      writeback completions
//            wb_redirect_i/sid_i      redirect, squash younger entries
//            rd_busy_o                per-register pending-write bits
//            retire_cnt_o             entries retired this cycle
//            sb_empty_o               no live entries
// Config   : SB_WB_BYPASS_EN - same-cycle writeback wakeup on rd_busy_o
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_scoreboard
   import wb_scoreboard_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             iss0_valid_i,
   input  logic             iss0_wen_i,
   input  logic [4:0]       iss0_rd_i,
   input  logic             iss1_valid_i,
   input  logic             iss1_wen_i,
   input  logic [4:0]       iss1_rd_i,
   output logic             alloc_ready_o,
   output logic [SID_W-1:0] iss0_sid_o,
   output logic [SID_W-1:0] iss1_sid_o,
   input  logic             wb0_valid_i,
   input  logic [SID_W-1:0] wb0_sid_i,
   input  logic             wb1_valid_i,
   input  logic [SID_W-1:0] wb1_sid_i,
   input  logic             wb_redirect_i,
   input  logic [SID_W-1:0] wb_redirect_sid_i,
   output logic [31:0]      rd_busy_o,
   output logic [1:0]       retire_cnt_o,
   output logic             sb_empty_o
);

   logic [SID_W-1:0]    r_head;
   logic [SID_W-1:0]    r_tail;
   sb_entry_t           r_ent [SB_DEPTH];

   logic [SID_W-1:0]    w_count;
   logic                w_issue0;
   logic                w_issue1;
   logic                w_wb0_in_range;
   logic                w_wb1_in_range;
   logic                w_wb0_ok;
   logic                w_wb1_ok;
   logic [IDX_W-1:0]    w_h0;
   logic [IDX_W-1:0]    w_h1;
   logic                w_ret0;
   logic                w_ret1;
   logic [SB_DEPTH-1:0] w_squash;
   logic [SB_DEPTH-1:0] w_done_set;
   logic [SB_DEPTH-1:0] w_clear;
   logic [SB_DEPTH-1:0] w_alloc0;
   logic [SB_DEPTH-1:0] w_alloc1;
   logic [SB_DEPTH-1:0] w_wake;

   // Occupancy and allocation
   assign w_count       = r_tail - r_head;
   assign alloc_ready_o = (w_count <= SID_W'(SB_DEPTH - 2));
   assign sb_empty_o    = (w_count == '0);
   assign iss0_sid_o    = r_tail;
   assign iss1_sid_o    = r_tail + SID_W'(1);

   // A redirect in the same cycle drops the issue group entirely.
   assign w_issue0 = iss0_valid_i & alloc_ready_o & ~wb_redirect_i;
   assign w_issue1 = w_issue0 & iss1_valid_i;

   // Writeback accepted only for sids in [head, tail): tail younger than sid.
   sb_age_cmp u_wb0_live (
      .sid     (r_tail),
      .head    (r_head),
      .ref_sid (wb0_sid_i),
      .younger (w_wb0_in_range)
   );

   sb_age_cmp u_wb1_live (
      .sid     (r_tail),
      .head    (r_head),
      .ref_sid (wb1_sid_i),
      .younger (w_wb1_in_range)
   );

   assign w_wb0_ok = wb0_valid_i & w_wb0_in_range & r_ent[sid_idx(wb0_sid_i)].valid;
   assign w_wb1_ok = wb1_valid_i & w_wb1_in_range & r_ent[sid_idx(wb1_sid_i)].valid;

   // In-order retire from registered state. The second slot is held back if
   // a same-cycle redirect squashes it, so head can never pass the new tail.
   assign w_h0         = sid_idx(r_head);
   assign w_h1         = w_h0 + IDX_W'(1);
   assign w_ret0       = r_ent[w_h0].valid & r_ent[w_h0].done;
   assign w_ret1       = w_ret0 & r_ent[w_h1].valid & r_ent[w_h1].done & ~w_squash[w_h1];
   assign retire_cnt_o = {w_ret1, w_ret0 & ~w_ret1};

   generate
      for (genvar i = 0; i < SB_DEPTH; i++) begin : g_entry
         localparam logic [IDX_W-1:0] c_idx = IDX_W'(i);
         logic [SID_W-1:0] w_ent_sid;
         logic             w_younger;

         // Reconstruct the entry's full sid: indices below head's index have
         // wrapped once relative to head.
         assign w_ent_sid = {(c_idx >= w_h0) ? r_head[SID_W-1] : ~r_head[SID_W-1], c_idx};

         sb_age_cmp u_squash_cmp (
            .sid     (w_ent_sid),
            .head    (r_head),
            .ref_sid (wb_redirect_sid_i),
            .younger (w_younger)
         );

         assign w_squash[i]   = wb_redirect_i & r_ent[i].valid & w_younger;
         assign w_done_set[i] = (w_wb0_ok & (sid_idx(wb0_sid_i) == c_idx))
                              | (w_wb1_ok & (sid_idx(wb1_sid_i) == c_idx));
         assign w_clear[i]    = w_squash[i]
                              | (w_ret0 & (w_h0 == c_idx))
                              | (w_ret1 & (w_h1 == c_idx));
         assign w_alloc0[i]   = w_issue0 & (sid_idx(iss0_sid_o) == c_idx);
         assign w_alloc1[i]   = w_issue1 & (sid_idx(iss1_sid_o) == c_idx);
      end
   endgenerate

`ifdef SB_WB_BYPASS_EN
   assign w_wake = w_done_set;
`else
   assign w_wake = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head <= '0;
         r_tail <= '0;
         for (int i = 0; i < SB_DEPTH; i++) begin
            r_ent[i] <= '0;
         end
      end else begin
         r_head <= r_head + SID_W'(retire_cnt_o);
         if (wb_redirect_i) begin
            r_tail <= wb_redirect_sid_i + SID_W'(1);
         end else if (w_issue0) begin
            r_tail <= r_tail + (w_issue1 ? SID_W'(2) : SID_W'(1));
         end
         for (int i = 0; i < SB_DEPTH; i++) begin
            if (w_alloc0[i]) begin
               r_ent[i] <= {1'b1, 1'b0, iss0_wen_i, iss0_rd_i};
            end else if (w_alloc1[i]) begin
               r_ent[i] <= {1'b1, 1'b0, iss1_wen_i, iss1_rd_i};
            end
            if (w_done_set[i]) begin
               r_ent[i].done <= 1'b1;
            end
            // Retire and squash take priority over a same-cycle done.
            if (w_clear[i]) begin
               r_ent[i] <= '0;
            end
         end
      end
   end

   always_comb begin
      rd_busy_o = '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         if (r_ent[i].valid & ~r_ent[i].done & r_ent[i].wen & ~w_wake[i]) begin
            rd_busy_o[r_ent[i].rd] = 1'b1;
         end
      end
      rd_busy_o[0] = 1'b0;
   end

endmodule

`default_nettype wire

// File: tb/tb_wb_scoreboard.sv
//------------------------------------------------------------------------------
// Module   : tb_wb_scoreboard
// Purpose  : Directed self-checking bench for wb_scoreboard (8 entries,
//            4-bit sids). Honours SB_WB_BYPASS_EN for the wakeup timing check.
// Ports    : none
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_scoreboard;
   import wb_scoreboard_pkg::*;

   logic             clk;
   logic             rst_n;
   logic             iss0_valid_i;
   logic             iss0_wen_i;
   logic [4:0]       iss0_rd_i;
   logic             iss1_valid_i;
   logic             iss1_wen_i;
   logic [4:0]       iss1_rd_i;
   logic             alloc_ready_o;
   logic [SID_W-1:0] iss0_sid_o;
   logic [SID_W-1:0] iss1_sid_o;
   logic             wb0_valid_i;
   logic [SID_W-1:0] wb0_sid_i;
   logic             wb1_valid_i;
   logic [SID_W-1:0] wb1_sid_i;
   logic             wb_redirect_i;
   logic [SID_W-1:0] wb_redirect_sid_i;
   logic [31:0]      rd_busy_o;
   logic [1:0]       retire_cnt_o;
   logic             sb_empty_o;

   int checks = 0;
   int errors = 0;

   wb_scoreboard dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .iss0_valid_i      (iss0_valid_i),
      .iss0_wen_i        (iss0_wen_i),
      .iss0_rd_i         (iss0_rd_i),
      .iss1_valid_i      (iss1_valid_i),
      .iss1_wen_i        (iss1_wen_i),
      .iss1_rd_i         (iss1_rd_i),
      .alloc_ready_o     (alloc_ready_o),
      .iss0_sid_o        (iss0_sid_o),
      .iss1_sid_o        (iss1_sid_o),
      .wb0_valid_i       (wb0_valid_i),
      .wb0_sid_i         (wb0_sid_i),
      .wb1_valid_i       (wb1_valid_i),
      .wb1_sid_i         (wb1_sid_i),
      .wb_redirect_i     (wb_redirect_i),
      .wb_redirect_sid_i (wb_redirect_sid_i),
      .rd_busy_o         (rd_busy_o),
      .retire_cnt_o      (retire_cnt_o),
      .sb_empty_o        (sb_empty_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      iss0_valid_i = 0; iss0_wen_i = 0; iss0_rd_i = '0;
      iss1_valid_i = 0; iss1_wen_i = 0; iss1_rd_i = '0;
      wb0_valid_i = 0;  wb0_sid_i = '0;
      wb1_valid_i = 0;  wb1_sid_i = '0;
      wb_redirect_i = 0; wb_redirect_sid_i = '0;
   endtask

   task automatic issue(input logic v1, input logic [4:0] rd0, input logic [4:0] rd1);
      iss0_valid_i = 1; iss0_wen_i = 1; iss0_rd_i = rd0;
      iss1_valid_i = v1; iss1_wen_i = v1; iss1_rd_i = rd1;
      step();
      idle_inputs();
   endtask

   task automatic wb(input logic v0, input logic [SID_W-1:0] s0,
                     input logic v1, input logic [SID_W-1:0] s1);
      wb0_valid_i = v0; wb0_sid_i = s0;
      wb1_valid_i = v1; wb1_sid_i = s1;
      step();
      idle_inputs();
   endtask

   initial begin
      rst_n = 0;
      idle_inputs();
      step();
      step();
      // Reset state
      chk("rst_empty",  32'(sb_empty_o),    32'd1);
      chk("rst_ready",  32'(alloc_ready_o), 32'd1);
      chk("rst_sid0",   32'(iss0_sid_o),    32'd0);
      chk("rst_sid1",   32'(iss1_sid_o),    32'd1);
      chk("rst_busy",   rd_busy_o,          32'h0);
      chk("rst_retire", 32'(retire_cnt_o),  32'd0);
      rst_n = 1;
      step();

      // Pair issue rd5/rd6, out-of-order completion
      issue(1, 5'd5, 5'd6);
      chk("pair_busy",   rd_busy_o,       32'h60);
      chk("pair_tail",   32'(iss0_sid_o), 32'd2);
      wb(1, 4'd1, 0, 4'd0);
      chk("wb1_busy",    rd_busy_o,          32'h20);
      chk("wb1_retire",  32'(retire_cnt_o),  32'd0);
      wb(0, 4'd0, 1, 4'd0);
      chk("wb0_retire",  32'(retire_cnt_o),  32'd2);
      chk("wb0_busy",    rd_busy_o,          32'h0);
      step();
      chk("pair_empty",  32'(sb_empty_o),    32'd1);

      // Wakeup timing, sid2 rd9
      issue(0, 5'd9, 5'd0);
      chk("rd9_busy", rd_busy_o, 32'h200);
      wb0_valid_i = 1; wb0_sid_i = 4'd2;
      #1;
`ifdef SB_WB_BYPASS_EN
      chk("rd9_same_cycle", rd_busy_o, 32'h0);
`else
      chk("rd9_same_cycle", rd_busy_o, 32'h200);
`endif
      step();
      idle_inputs();
      chk("rd9_next_cycle", rd_busy_o,          32'h0);
      chk("rd9_retire",     32'(retire_cnt_o),  32'd1);
      step();
      chk("rd9_empty",      32'(sb_empty_o),    32'd1);

      // Mid-operation reset drops live entries
      issue(1, 5'd7, 5'd8);
      chk("pre_rst_busy", rd_busy_o, 32'h180);
      rst_n = 0;
      #1;
      chk("midrst_empty", 32'(sb_empty_o), 32'd1);
      chk("midrst_busy",  rd_busy_o,       32'h0);
      step();
      rst_n = 1;
      step();
      chk("midrst_sid0", 32'(iss0_sid_o), 32'd0);

      // Fill to 7 live, overflow issue ignored
      issue(1, 5'd10, 5'd11);
      issue(1, 5'd12, 5'd13);
      issue(1, 5'd14, 5'd15);
      chk("six_ready", 32'(alloc_ready_o), 32'd1);
      issue(0, 5'd16, 5'd0);
      chk("seven_ready", 32'(alloc_ready_o), 32'd0);
      chk("seven_sid0",  32'(iss0_sid_o),    32'd7);
      issue(1, 5'd20, 5'd21);
      chk("ovf_sid0",    32'(iss0_sid_o),    32'd7);
      chk("ovf_busy",    rd_busy_o,          32'h1FC00);

      // Drain; last writeback hits the same sid on both ports
      wb(1, 4'd0, 1, 4'd1);
      wb(1, 4'd2, 1, 4'd3);
      wb(1, 4'd4, 1, 4'd5);
      wb(1, 4'd6, 1, 4'd6);
      chk("drain_busy", rd_busy_o, 32'h0);
      step();
      chk("drain_empty", 32'(sb_empty_o), 32'd1);
      chk("drain_sid0",  32'(iss0_sid_o), 32'd7);

      // rd=0 never busy; wrap of the sid
      issue(0, 5'd0, 5'd0);
      chk("rd0_busy",  rd_busy_o,        32'h0);
      chk("rd0_empty", 32'(sb_empty_o), 32'd0);
      wb(1, 4'd7, 1, 4'd7);
      chk("rd0_retire", 32'(retire_cnt_o), 32'd1);
      step();
      chk("wrap_sid0", 32'(iss0_sid_o), 32'd8);
      chk("wrap_sid1", 32'(iss1_sid_o), 32'd9);

      // Live sids 8..12 (rd1..rd5), redirect at sid9 with a same-cycle issue
      issue(1, 5'd1, 5'd2);
      issue(1, 5'd3, 5'd4);
      issue(0, 5'd5, 5'd0);
      chk("redir_pre_busy", rd_busy_o, 32'h3E);
      wb_redirect_i = 1; wb_redirect_sid_i = 4'd9;
      iss0_valid_i = 1; iss0_wen_i = 1; iss0_rd_i = 5'd20;
      step();
      idle_inputs();
      chk("redir_tail", 32'(iss0_sid_o), 32'd10);
      chk("redir_busy", rd_busy_o,       32'h6);
      wb(1, 4'd11, 0, 4'd0);
      chk("stale_wb_busy",   rd_busy_o,          32'h6);
      chk("stale_wb_retire", 32'(retire_cnt_o),  32'd0);
      wb(1, 4'd8, 1, 4'd9);
      chk("redir_retire", 32'(retire_cnt_o), 32'd2);
      chk("redir_busy0",  rd_busy_o,         32'h0);
      step();
      chk("redir_empty", 32'(sb_empty_o), 32'd1);
      chk("redir_sid0",  32'(iss0_sid_o), 32'd10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
